// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- central sequencer for the 16-bit 5-stage core.
//
// Drives the enable/flush controls of the pc, if/id, id/ex, ex/mem and mem/wb
// registers. Handles load-use stalls, taken-branch squash, the data-memory wait
// handshake with timeout, and the halt drain. Outputs are combinational from the
// registered state and the current inputs, so they act in the same cycle.
//
// Optional feature: define PIPELINE_CTRL_PERF_CNT_EN to build the stall/flush
// performance counters. Without it both count ports read 16'h0000 and no
// counter flops exist.
//
// Ports
//   clk_i                 clock, rising edge
//   rst_ni                asynchronous reset, active low
//   main_mem_read_ex_i    instruction in EX is a load
//   regwrite_adr_ex_i     destination register of the EX instruction
//   rs_adr_id_i/rt_adr_id_i  source registers of the ID instruction
//   uses_rs_id_i/uses_rt_id_i  ID instruction reads rs / rt
//   branch_taken_ex_i     branch in EX resolved taken
//   is_halt_ex_i          HLT in EX
//   mem_req_mem_i         load/store in MEM needs data memory
//   mem_ack_i             data memory completes the access this cycle
//   restart_i             one-cycle pulse, leaves HALTED
//   en_*_o                stage register enables
//   flush_ifid_o/flush_idex_o  synchronous bubble insert
//   halted_o              core frozen
//   mem_err_o             sticky memory-timeout flag, cleared by restart
//   stall_count_o         load-use plus mem-wait stall cycles (saturating)
//   flush_count_o         taken-branch squash events (saturating)
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        main_mem_read_ex_i,
    input  logic [2:0]  regwrite_adr_ex_i,
    input  logic [2:0]  rs_adr_id_i,
    input  logic [2:0]  rt_adr_id_i,
    input  logic        uses_rs_id_i,
    input  logic        uses_rt_id_i,
    input  logic        branch_taken_ex_i,
    input  logic        is_halt_ex_i,
    input  logic        mem_req_mem_i,
    input  logic        mem_ack_i,
    input  logic        restart_i,
    output logic        en_pc_o,
    output logic        en_ifid_o,
    output logic        en_idex_o,
    output logic        en_exmem_o,
    output logic        en_memwb_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        halted_o,
    output logic        mem_err_o,
    output logic [15:0] stall_count_o,
    output logic [15:0] flush_count_o
);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_e;

    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic [4:0] en;     // {pc, ifid, idex, exmem, memwb}
    logic [1:0] fl;     // {ifid, idex}
    logic       halted;
    logic       stall_inc, flush_inc;
    logic       run_eval;
    logic       mem_stall, load_use;

    assign mem_stall = mem_req_mem_i & ~mem_ack_i;
    assign load_use  = main_mem_read_ex_i &
                       ((uses_rs_id_i & (rs_adr_id_i == regwrite_adr_ex_i)) |
                        (uses_rt_id_i & (rt_adr_id_i == regwrite_adr_ex_i)));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        en        = 5'b00000;
        fl        = 2'b00;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        run_eval  = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEMWAIT;
                    wait_d  = 8'd1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEMWAIT: begin
                stall_inc = 1'b1;
                if (mem_ack_i) begin
                    run_eval = 1'b1;
                end else if (wait_q == TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = HALTED;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DRAIN: begin
                // A memory access still retiring in MEM freezes the drain;
                // the drain count holds and the wait counter runs instead.
                if (mem_stall) begin
                    stall_inc = 1'b1;
                    if (wait_q == TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end else begin
                    en     = 5'b00011;
                    wait_d = 8'd0;
                    if (cnt_q == DRAIN_LAST) state_d = HALTED;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (restart_i) begin
                    state_d = RUN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase

        // Normal-flow rules, shared by RUN and the ack cycle of MEMWAIT.
        if (run_eval) begin
            state_d = RUN;
            if (is_halt_ex_i) begin
                en      = 5'b00011;
                fl      = 2'b11;
                state_d = DRAIN;
                cnt_d   = 8'd0;
                wait_d  = 8'd0;
            end else if (branch_taken_ex_i) begin
                en        = 5'b11111;
                fl        = 2'b11;
                flush_inc = 1'b1;
            end else if (load_use) begin
                en        = 5'b00111;
                fl        = 2'b01;
                stall_inc = 1'b1;
            end else begin
                en = 5'b11111;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            wait_q  <= 8'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Reset forces the combinational controls low immediately.
    assign en_pc_o      = rst_ni & en[4];
    assign en_ifid_o    = rst_ni & en[3];
    assign en_idex_o    = rst_ni & en[2];
    assign en_exmem_o   = rst_ni & en[1];
    assign en_memwb_o   = rst_ni & en[0];
    assign flush_ifid_o = rst_ni & fl[1];
    assign flush_idex_o = rst_ni & fl[0];
    assign halted_o     = rst_ni & halted;
    assign mem_err_o    = err_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
        if (flush_inc && flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_count_o = stall_q;
    assign flush_count_o = flush_q;
`else
    logic unused_perf;
    assign unused_perf   = stall_inc ^ flush_inc;
    assign stall_count_o = 16'h0000;
    assign flush_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. The driver sets inputs just after each rising
// edge and queues the outputs expected for that cycle; a monitor samples on the
// falling edge and checks against the queue head.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mrd, br, hlt, mreq, ack, rst_pulse, urs, urt;
    logic [2:0]  wadr, rs, rt;
    logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic        fl_ifid, fl_idex, halted, mem_err;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    logic [40:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(15)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .main_mem_read_ex_i(mrd), .regwrite_adr_ex_i(wadr),
        .rs_adr_id_i(rs), .rt_adr_id_i(rt),
        .uses_rs_id_i(urs), .uses_rt_id_i(urt),
        .branch_taken_ex_i(br), .is_halt_ex_i(hlt),
        .mem_req_mem_i(mreq), .mem_ack_i(ack), .restart_i(rst_pulse),
        .en_pc_o(en_pc), .en_ifid_o(en_ifid), .en_idex_o(en_idex),
        .en_exmem_o(en_exmem), .en_memwb_o(en_memwb),
        .flush_ifid_o(fl_ifid), .flush_idex_o(fl_idex),
        .halted_o(halted), .mem_err_o(mem_err),
        .stall_count_o(stall_cnt), .flush_count_o(flush_cnt)
    );

    // Counts read zero when the performance counters are not built.
    function automatic logic [15:0] cnt(input int v);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(v * 0);
`endif
    endfunction

    task automatic idle();
        mrd = 0; br = 0; hlt = 0; mreq = 0; ack = 0; rst_pulse = 0;
        urs = 0; urt = 0; wadr = 0; rs = 0; rt = 0;
    endtask

    // en = {pc,ifid,idex,exmem,memwb}, fl = {ifid,idex}
    task automatic step(input string nm, input logic [4:0] en, input logic [1:0] fl,
                        input logic h, input logic e, input int st, input int fc);
        exp_q.push_back({en, fl, h, e, cnt(st), cnt(fc)});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [40:0] act, ex;
            string nm;
            ex = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {en_pc, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex,
                   halted, mem_err, stall_cnt, flush_cnt};
            tests++;
            if (act !== ex) begin
                fails++;
                $display("FAIL %s: got en=%b fl=%b h=%b err=%b st=%0d fc=%0d, want en=%b fl=%b h=%b err=%b st=%0d fc=%0d",
                         nm, act[40:36], act[35:34], act[33], act[32], act[31:16], act[15:0],
                         ex[40:36], ex[35:34], ex[33], ex[32], ex[31:16], ex[15:0]);
            end
        end
    end

    initial begin
        rst_n = 0;
        idle();
        @(posedge clk);
        #1;
        // reset state
        repeat (3) step("reset", 5'b00000, 2'b00, 0, 0, 0, 0);
        rst_n = 1;
        step("run", 5'b11111, 2'b00, 0, 0, 0, 0);

        // load-use on rs
        mrd = 1; wadr = 3; urs = 1; rs = 3;
        step("lu_rs", 5'b00111, 2'b01, 0, 0, 0, 0);
        urs = 0;
        step("lu_rs_unused", 5'b11111, 2'b00, 0, 0, 1, 0);
        urt = 1; rt = 3; rs = 5;
        step("lu_rt", 5'b00111, 2'b01, 0, 0, 1, 0);
        urt = 0; urs = 1; rs = 4;
        step("lu_miss", 5'b11111, 2'b00, 0, 0, 2, 0);
        mrd = 0; rs = 3;
        step("no_load", 5'b11111, 2'b00, 0, 0, 2, 0);

        // branch beats load-use
        mrd = 1; br = 1;
        step("br_lu", 5'b11111, 2'b11, 0, 0, 2, 0);
        idle();
        step("after_br", 5'b11111, 2'b00, 0, 0, 2, 1);

        // memory wait, 4 stalled cycles then ack
        mreq = 1; ack = 0;
        step("mw_enter", 5'b00000, 2'b00, 0, 0, 2, 1);
        step("mw1", 5'b00000, 2'b00, 0, 0, 2, 1);
        step("mw2", 5'b00000, 2'b00, 0, 0, 3, 1);
        step("mw3", 5'b00000, 2'b00, 0, 0, 4, 1);
        ack = 1;
        step("mw_ack", 5'b11111, 2'b00, 0, 0, 5, 1);
        step("mem_hit", 5'b11111, 2'b00, 0, 0, 6, 1);
        idle();
        step("mw_done", 5'b11111, 2'b00, 0, 0, 6, 1);

        // memory timeout
        mreq = 1; ack = 0;
        step("to_enter", 5'b00000, 2'b00, 0, 0, 6, 1);
        for (int i = 0; i < 15; i++)
            step("to_wait", 5'b00000, 2'b00, 0, 0, 6 + i, 1);
        step("to_halted", 5'b00000, 2'b00, 1, 1, 21, 1);
        rst_pulse = 1;
        step("to_restart", 5'b00000, 2'b00, 1, 1, 21, 1);
        idle();
        step("to_resume", 5'b11111, 2'b00, 0, 0, 21, 1);
        rst_pulse = 1;
        step("restart_ign", 5'b11111, 2'b00, 0, 0, 21, 1);
        rst_pulse = 0;
        step("restart_ign2", 5'b11111, 2'b00, 0, 0, 21, 1);

        // halt drain
        hlt = 1;
        step("hlt", 5'b00011, 2'b11, 0, 0, 21, 1);
        hlt = 0;
        step("drain0", 5'b00011, 2'b00, 0, 0, 21, 1);
        step("drain1", 5'b00011, 2'b00, 0, 0, 21, 1);
        step("halted", 5'b00000, 2'b00, 1, 0, 21, 1);
        step("halted_hold", 5'b00000, 2'b00, 1, 0, 21, 1);
        rst_pulse = 1;
        step("hlt_restart", 5'b00000, 2'b00, 1, 0, 21, 1);
        rst_pulse = 0;
        step("hlt_run", 5'b11111, 2'b00, 0, 0, 21, 1);

        // reset during drain
        hlt = 1;
        step("hlt2", 5'b00011, 2'b11, 0, 0, 21, 1);
        hlt = 0; rst_n = 0;
        step("rst_in_drain", 5'b00000, 2'b00, 0, 0, 0, 0);
        rst_n = 1;
        step("rst_run", 5'b11111, 2'b00, 0, 0, 0, 0);

        // memory freeze inside drain
        hlt = 1;
        step("hlt3", 5'b00011, 2'b11, 0, 0, 0, 0);
        hlt = 0; mreq = 1; ack = 0;
        step("dr_freeze", 5'b00000, 2'b00, 0, 0, 0, 0);
        ack = 1;
        step("dr_ack", 5'b00011, 2'b00, 0, 0, 1, 0);
        idle();
        step("dr1", 5'b00011, 2'b00, 0, 0, 1, 0);
        step("halted3", 5'b00000, 2'b00, 1, 0, 1, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_queue: %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
